// File: rtl/m_chk_pkg.sv
// m_chk_pkg: shared constants for the x^4+x^3+1 m-sequence checker.
// Holds FSM state codes, the sequence period and the feedback tap function.
package m_chk_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

  localparam int M_PERIOD = 15;

  function automatic logic m_fb(input logic [3:0] q);
    return q[3] ^ q[0];
  endfunction

endpackage

// File: rtl/m_chk_if.sv
// m_chk_if: serial link bundle between the receive side and the checker.
// din/clr go toward the checker; lock/err/err_cnt come back out of it.
interface m_chk_if #(
  parameter int ERR_W = 8
) ();

  logic             din;
  logic             clr;
  logic             lock;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output din, clr,
    input  lock, err, err_cnt
  );

  modport slave (
    input  din, clr,
    output lock, err, err_cnt
  );

endinterface

// File: rtl/m_chk_step.sv
// m_chk_step: one combinational step of a 4-bit m-sequence register.
// q: state (q[0] oldest), ext/d: shift in d instead of p, nxt: next state, p: predicted bit.
module m_chk_step
  import m_chk_pkg::*;
(
  input  logic [3:0] q,
  input  logic       ext,
  input  logic       d,
  output logic [3:0] nxt,
  output logic       p
);

  always_comb begin
    p   = m_fb(q);
    nxt = {(ext ? d : p), q[3:1]};
  end

endmodule

// File: rtl/m_chk.sv
// m_chk: self-synchronising checker for the 15-bit m-sequence, flywheel in LOCK.
// clk, res (async, active low), bus: din/clr in, lock/err/err_cnt out.
module m_chk
  import m_chk_pkg::*;
#(
  parameter int SYNC_CNT = 8,
  parameter int LOSS_THR = 3,
  parameter int ERR_W    = 8
) (
  input logic  clk,
  input logic  res,
  m_chk_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       h_q, h_d;
  logic [3:0]       l_q, l_d;
  logic [1:0]       fc_q, fc_d;
  logic [3:0]       ok_cnt_q, ok_cnt_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [3:0]       wer_q, wer_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0] h_nxt, l_nxt;
  logic       h_p, l_p;
  logic [3:0] ok_inc;
  logic [3:0] wer_nx;
  logic       mis;

  m_chk_step u_h_step (
    .q   (h_q),
    .ext (1'b1),
    .d   (bus.din),
    .nxt (h_nxt),
    .p   (h_p)
  );

  m_chk_step u_l_step (
    .q   (l_q),
    .ext (1'b0),
    .d   (bus.din),
    .nxt (l_nxt),
    .p   (l_p)
  );

  assign ok_inc = ok_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    l_d       = l_q;
    fc_d      = fc_q;
    ok_cnt_d  = ok_cnt_q;
    wcnt_d    = wcnt_q;
    wer_d     = wer_q;
    err_cnt_d = err_cnt_q;
    mis       = 1'b0;
    wer_nx    = wer_q;

    unique case (state_q)
      ST_SEARCH: begin
        h_d = h_nxt;
        if (fc_q == 2'd3) begin
          // all-zero history is the lock-up state; keep sampling
          if (h_nxt != 4'd0) begin
            state_d  = ST_VERIFY;
            ok_cnt_d = 4'd0;
          end
        end else begin
          fc_d = fc_q + 2'd1;
        end
      end
      ST_VERIFY: begin
        h_d = h_nxt;
        if (h_nxt == 4'd0) begin
          state_d = ST_SEARCH;
          fc_d    = 2'd3;
        end else if (bus.din == h_p) begin
          ok_cnt_d = ok_inc;
          if (ok_inc == 4'(SYNC_CNT)) begin
            state_d = ST_LOCK;
            l_d     = h_nxt;
            wcnt_d  = 4'd0;
            wer_d   = 4'd0;
          end
        end else begin
          ok_cnt_d = 4'd0;
        end
      end
      ST_LOCK: begin
        // flywheel: received bits never enter l
        l_d    = l_nxt;
        mis    = bus.din ^ l_p;
        wer_nx = wer_q + {3'd0, mis};
        if (wcnt_q == 4'(M_PERIOD - 1)) begin
          wcnt_d = 4'd0;
          wer_d  = 4'd0;
          if (wer_nx >= 4'(LOSS_THR)) begin
            state_d = ST_SEARCH;
            fc_d    = 2'd0;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
          wer_d  = wer_nx;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        fc_d    = 2'd0;
      end
    endcase

    if (mis && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    if (bus.clr) begin
      err_cnt_d = '0;
    end

    err_d  = mis;
    lock_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= ST_SEARCH;
      h_q       <= 4'd0;
      l_q       <= 4'd0;
      fc_q      <= 2'd0;
      ok_cnt_q  <= 4'd0;
      wcnt_q    <= 4'd0;
      wer_q     <= 4'd0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      l_q       <= l_d;
      fc_q      <= fc_d;
      ok_cnt_q  <= ok_cnt_d;
      wcnt_q    <= wcnt_d;
      wer_q     <= wer_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.lock    = lock_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule
